tap_launch_scheduler: RTL and testbench
=======================================

// Module: tap_launch_scheduler
// PURPOSE
//  Shares one launch register and a NUM_TAPS-deep capture delay line between NUM_REQ requesters.
//  Each requester names a tap depth from 1 to NUM_TAPS, which selects the number of delay stages.
//  A round-robin arbiter grants one launch at a time. The launched bit propagates down the line.
//  The bit is captured at the requested tap and returned tagged with the requester id.
//  Sits between the path-group test drivers and the reg-to-reg delay datapath; all logic on clk.
// PARAMETERS
//  NUM_REQ   5  number of requesters (1..8)
//  NUM_TAPS  6  delay-line stages (1..7)
//  TAP_W     3  width of each tap-select field; must satisfy 2**TAP_W > NUM_TAPS
//  ID_W      3  width of cap_id; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk         in   1               single clock, rising edge
//  rst         in   1               synchronous reset, active-high
//  enable      in   1               0: no new grants; an in-flight transaction still completes
//  req         in   NUM_REQ         per-requester launch request; held high until granted
//  req_tap     in   NUM_REQ*TAP_W   per-requester tap depth; field i = [i*TAP_W +: TAP_W]
//  req_data    in   NUM_REQ         per-requester bit to launch
//  grant       out  NUM_REQ         one-hot, one-cycle pulse: request accepted
//  busy        out  1               high whenever state != IDLE
//  cap_valid   out  1               one-cycle pulse: capture result is valid
//  cap_id      out  ID_W            index of the requester that owns the capture
//  cap_data    out  1               captured bit
//  cap_tap     out  TAP_W           effective (clamped) tap used for the capture
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; round-robin pointer 0; delay line all 0.
//  Reset mid-transaction: the transaction is abandoned and no cap_valid is issued.
//  Delay line: line[0] <= launch_bit, line[i] <= line[i-1] on every clk edge.
//   launch_bit is 0 except in the LAUNCH cycle.
//  Tap clamp: tap 0 is treated as 1; tap > NUM_TAPS is treated as NUM_TAPS.
//  FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
//   IDLE: if enable and |req, pick the winner round-robin and go to LAUNCH.
//    On the same edge, latch id, clamped tap and data.
//   LAUNCH (cycle G): grant[id] = 1, launch_bit = latched data.
//    If tap == 1, go to CAPTURE; otherwise go to WAIT.
//   WAIT: count down the stages. Go to CAPTURE so that the CAPTURE cycle is G+tap.
//   CAPTURE (cycle G+tap): line[tap-1] holds the launched bit. Register it into cap_data.
//    Register cap_id and cap_tap on the same edge, then go to IDLE.
//   cap_valid is high in cycle G+tap+1 only, which is also the next IDLE arbitration cycle.
//  Latency: request seen in IDLE at cycle T -> grant at T+1 -> cap_valid at T+1+tap+1.
//  Back-to-back: a new winner may be chosen in the same cycle as cap_valid.
//  Round robin: the search starts at the pointer. After a grant, pointer = (id+1) mod NUM_REQ.
//   With a single active requester, that requester is granted every transaction.
//  Requests arriving while busy are ignored until IDLE; req is not sticky inside the block.
//  Deasserting enable while busy has no effect on the in-flight transaction.
//  Simultaneous requests: exactly one grant; the others wait; none is dropped while req stays high.
// STRUCTURE
//  Package tap_sched_pkg holds:
//   state enum {IDLE, LAUNCH, WAIT, CAPTURE} (2 bits);
//   function clamp_tap(tap, NUM_TAPS);
//   localparam defaults for NUM_TAPS and NUM_REQ.
//  Sub-module rr_arbiter #(N): inputs req, pointer, advance; outputs one-hot winner, winner index.
//   Combinational pick, registered pointer, synchronous rst.
//  Top module: FSM, stage counter, latched transaction fields, delay line, capture registers.
// TESTING
//  1. Reset held 3 cycles during WAIT -> no cap_valid; all outputs 0 one cycle after rst falls.
//  2. req[0]=1, tap=1, data=1 at T -> grant=5'b00001 at T+1; cap_valid=1, cap_data=1, cap_id=0 at T+3.
//  3. req[2], tap=6, data=1 -> cap_valid exactly 8 cycles after req is first sampled in IDLE;
//     busy is high for 7 cycles.
//  4. req=5'b11111 held for 10 transactions -> grant order 0,1,2,3,4,0,...; each id is granted exactly twice.
//  5. tap=0 -> cap_tap=1 and tap-1 timing; tap=7 with NUM_TAPS=6 -> cap_tap=6 and tap-6 timing.
//  6. enable dropped during WAIT -> the capture still completes; no further grant until enable=1.
//     Alternating data 1,0,1 on consecutive transactions -> cap_data follows 1,0,1.

Source files
------------

// File: rtl/tap_sched_pkg.sv
// tap_sched_pkg: shared state encoding, tap clamp helper and default sizes for the tap launch scheduler
package tap_sched_pkg;
  localparam int NUM_REQ_DEF = 5;
  localparam int NUM_TAPS_DEF = 6;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, CAPTURE} state_t;
  function automatic int clamp_tap(input int tap, input int num_taps);
    return tap < 1 ? 1 : tap > num_taps ? num_taps : tap;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick starting at a registered pointer that moves past each accepted winner
module rr_arbiter #(
  parameter int N = 5,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx
);
  logic [IW-1:0] pointer;
  always_comb begin
    winner_idx = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(pointer) + k) % N]) winner_idx = IW'((int'(pointer) + k) % N);
    winner = |req ? N'(1) << winner_idx : '0;
  end
  always_ff @(posedge clk)
    if (rst) pointer <= '0;
    else if (advance) pointer <= int'(winner_idx) == N - 1 ? '0 : winner_idx + 1'b1;
endmodule

// File: rtl/tap_launch_scheduler.sv
// tap_launch_scheduler: arbitrates launches into a shared delay line and returns the bit captured at each requester's tap
module tap_launch_scheduler
  import tap_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int NUM_TAPS = NUM_TAPS_DEF,
  parameter int TAP_W = 3,
  parameter int ID_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*TAP_W-1:0] req_tap,
  input  logic [NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     cap_valid,
  output logic [ID_W-1:0]          cap_id,
  output logic                     cap_data,
  output logic [TAP_W-1:0]         cap_tap
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  state_t state, state_n;
  logic [NUM_REQ-1:0] win;
  logic [IW-1:0] win_idx;
  logic [ID_W-1:0] id_q;
  logic [TAP_W-1:0] tap_q, cnt;
  logic data_q, advance, launch_bit;
  logic [NUM_TAPS-1:0] line;
  assign advance = state == IDLE && enable && |req;
  assign launch_bit = state == LAUNCH && data_q;
  assign busy = state != IDLE;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk), .rst(rst), .req(req), .advance(advance), .winner(win), .winner_idx(win_idx)
  );
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (advance ? LAUNCH : IDLE) :
              state == LAUNCH ? (tap_q == TAP_W'(1) ? CAPTURE : WAIT) :
              state == WAIT   ? (cnt == '0 ? CAPTURE : WAIT) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      id_q <= '0;
      tap_q <= '0;
      data_q <= 1'b0;
      cnt <= '0;
      line <= '0;
      grant <= '0;
      cap_valid <= 1'b0;
      cap_id <= '0;
      cap_data <= 1'b0;
      cap_tap <= '0;
    end else begin
      line <= (line << 1) | NUM_TAPS'(launch_bit);
      grant <= advance ? win : '0;
      cap_valid <= state == CAPTURE;
      if (advance) begin
        id_q <= ID_W'(win_idx);
        tap_q <= TAP_W'(clamp_tap(int'(req_tap[win_idx*TAP_W +: TAP_W]), NUM_TAPS));
        data_q <= req_data[win_idx];
      end
      // WAIT lasts tap-1 cycles so CAPTURE lands on the cycle the bit reaches line[tap-1]
      if (state == LAUNCH) cnt <= tap_q - TAP_W'(2);
      else if (state == WAIT) cnt <= cnt - 1'b1;
      if (state == CAPTURE) begin
        cap_data <= line[tap_q - 1'b1];
        cap_id <= id_q;
        cap_tap <= tap_q;
      end
    end
endmodule

// File: tb/tb_tap_launch_scheduler.sv
// tb_tap_launch_scheduler: directed self-checking bench for tap_launch_scheduler
module tb_tap_launch_scheduler;
  logic clk = 1'b0;
  logic rst, enable;
  logic [4:0] req, req_data, grant;
  logic [14:0] req_tap;
  logic busy, cap_valid, cap_data;
  logic [2:0] cap_id, cap_tap;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tap_launch_scheduler dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .req_tap(req_tap), .req_data(req_data),
    .grant(grant), .busy(busy), .cap_valid(cap_valid), .cap_id(cap_id), .cap_data(cap_data),
    .cap_tap(cap_tap)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run_txn(input int id, input int tap, input bit d, input int etap);
    int lat, bcnt;
    bit got;
    req = 5'(1) << id;
    req_tap[id*3 +: 3] = 3'(tap);
    req_data[id] = d;
    step();
    check("txn_grant", 32'(grant), 32'(5'(1) << id));
    req = '0;
    lat = 1;
    bcnt = int'(busy);
    got = 1'b0;
    while (!got && lat < 20) begin
      step();
      lat++;
      if (cap_valid) got = 1'b1;
      else bcnt += int'(busy);
    end
    check("txn_cap_valid", 32'(got), 32'd1);
    check("txn_latency", 32'(lat), 32'(etap + 2));
    check("txn_busy_cycles", 32'(bcnt), 32'(etap + 1));
    check("txn_cap_id", 32'(cap_id), 32'(id));
    check("txn_cap_data", 32'(cap_data), 32'(d));
    check("txn_cap_tap", 32'(cap_tap), 32'(etap));
  endtask
  initial begin
    int seen, ng, idx;
    int order[10];
    int cnt[5];
    rst = 1'b1;
    enable = 1'b1;
    req = '0;
    req_tap = '0;
    req_data = '0;
    step();
    step();
    check("reset_grant", 32'(grant), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_cap_valid", 32'(cap_valid), 0);
    rst = 1'b0;
    req = 5'b00100;
    req_tap[6 +: 3] = 3'd6;
    req_data[2] = 1'b1;
    step();
    check("pre_abort_launch", 32'(grant), 32'b00100);
    req = '0;
    step();
    check("pre_abort_busy", 32'(busy), 1);
    rst = 1'b1;
    step();
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_outputs", 32'({grant, busy, cap_valid, cap_id, cap_data, cap_tap}), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen += int'(cap_valid);
    end
    check("abort_no_cap_valid", 32'(seen), 0);
    req = 5'b00001;
    req_tap[0 +: 3] = 3'd1;
    req_data[0] = 1'b1;
    step();
    check("t2_grant", 32'(grant), 32'b00001);
    req = '0;
    step();
    check("t2_no_cap_yet", 32'(cap_valid), 0);
    step();
    check("t2_cap_valid", 32'(cap_valid), 1);
    check("t2_cap_data", 32'(cap_data), 1);
    check("t2_cap_id", 32'(cap_id), 0);
    step();
    check("t2_cap_pulse", 32'(cap_valid), 0);
    run_txn(2, 6, 1'b1, 6);
    run_txn(4, 0, 1'b1, 1);
    run_txn(3, 7, 1'b1, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    req_tap = {5{3'd1}};
    req_data = 5'b01010;
    req = 5'b11111;
    ng = 0;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      step();
      if (grant != '0) begin
        idx = 0;
        for (int b = 0; b < 5; b++) if (grant[b]) idx = b;
        order[ng] = idx;
        ng++;
        if (ng == 10) req = '0;
      end
    end
    check("rr_grant_count", 32'(ng), 10);
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    for (int i = 0; i < ng; i++) begin
      check("rr_order", 32'(order[i]), 32'(i % 5));
      cnt[order[i]]++;
    end
    for (int i = 0; i < 5; i++) check("rr_twice", 32'(cnt[i]), 2);
    for (int i = 0; i < 6; i++) step();
    req = 5'b00010;
    req_tap[3 +: 3] = 3'd4;
    req_data[1] = 1'b1;
    step();
    check("t6_grant", 32'(grant), 32'b00010);
    step();
    enable = 1'b0;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      step();
      if (cap_valid) seen = 1;
    end
    check("t6_cap_with_enable_low", 32'(seen), 1);
    check("t6_cap_id", 32'(cap_id), 1);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(grant != '0);
      step();
    end
    check("t6_no_grant_disabled", 32'(seen), 0);
    check("t6_idle_disabled", 32'(busy), 0);
    enable = 1'b1;
    step();
    check("t6_grant_reenabled", 32'(grant), 32'b00010);
    req = '0;
    for (int i = 0; i < 8; i++) step();
    run_txn(3, 2, 1'b1, 2);
    run_txn(3, 2, 1'b0, 2);
    run_txn(3, 2, 1'b1, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
